// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: single-cycle ops complete in IDLE, signed MUL iterates one bit per cycle in BUSY.
// Handshake is valid/ready on input; out_valid is a one-cycle pulse with registered result and {Z,N,C,V} flags.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] s1,
    input  logic [WIDTH-1:0] s2,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] ex_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_NAND = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_IN   = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [3:0] OP_SHLN = 4'hA;
    localparam logic [3:0] OP_SHRN = 4'hB;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_LDI  = 4'hF;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_out_valid;
    logic [SHW-1:0]     r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic               r_neg;

    logic [SHW-1:0]     w_amt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH:0]     w_shln;
    logic [WIDTH:0]     w_shrn;
    logic [WIDTH-1:0]   w_res;
    logic [3:0]         w_fl;
    logic               w_set_zn;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [2*WIDTH-1:0] w_acc_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_prod_hi;
    logic               w_mul_v;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;

    // Extra bit on each shift catches the last bit shifted out; it stays 0 for a zero amount.
    assign w_amt  = s2[SHW-1:0];
    assign w_add  = {1'b0, s1} + {1'b0, s2};
    assign w_sub  = s1 - s2;
    assign w_shln = {1'b0, s1} << w_amt;
    assign w_shrn = {s1, 1'b0} >> w_amt;

    always_comb begin
        w_res    = '0;
        w_fl     = r_flags;
        w_set_zn = 1'b0;
        case (op)
            OP_ADD: begin
                w_res    = w_add[WIDTH-1:0];
                w_set_zn = 1'b1;
                w_fl[1]  = w_add[WIDTH];
                w_fl[0]  = (s1[WIDTH-1] == s2[WIDTH-1]) && (w_add[WIDTH-1] != s1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res    = w_sub;
                w_set_zn = 1'b1;
                w_fl[1]  = (s1 < s2);
                w_fl[0]  = (s1[WIDTH-1] != s2[WIDTH-1]) && (w_sub[WIDTH-1] != s1[WIDTH-1]);
            end
            OP_NAND: begin
                w_res    = ~(s1 & s2);
                w_set_zn = 1'b1;
            end
            OP_SHL: begin
                w_res    = {s1[WIDTH-2:0], 1'b0};
                w_set_zn = 1'b1;
                w_fl[1]  = s1[WIDTH-1];
            end
            OP_SHR: begin
                w_res    = {1'b0, s1[WIDTH-1:1]};
                w_set_zn = 1'b1;
                w_fl[1]  = s1[0];
            end
            OP_SHLN: begin
                w_res    = w_shln[WIDTH-1:0];
                w_set_zn = 1'b1;
                w_fl[1]  = w_shln[WIDTH];
            end
            OP_SHRN: begin
                w_res    = w_shrn[WIDTH:1];
                w_set_zn = 1'b1;
                w_fl[1]  = w_shrn[0];
            end
            OP_OUT:  w_res = s1;
            OP_IN:   w_res = ex_in;
            OP_MOV:  w_res = s2;
            OP_STR:  w_res = s1;
            OP_LDI:  w_res = imm;
            default: w_res = '0;
        endcase
        if (w_set_zn) begin
            w_fl[3] = (w_res == '0);
            w_fl[2] = w_res[WIDTH-1];
        end
    end

    // Multiply works on magnitudes; the most negative operand still fits as an unsigned magnitude.
    assign w_abs1    = s1[WIDTH-1] ? (~s1 + 1'b1) : s1;
    assign w_abs2    = s2[WIDTH-1] ? (~s2 + 1'b1) : s2;
    assign w_acc_sum = r_acc + (r_mplr[0] ? r_mcand : '0);
    assign w_prod    = r_neg ? (~w_acc_sum + 1'b1) : w_acc_sum;
    assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_v   = !((&w_prod_hi) || !(|w_prod_hi));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
            r_count     <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplr      <= '0;
            r_neg       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MUL) begin
                            r_state <= BUSY;
                            r_count <= SHW'(WIDTH - 1);
                            r_acc   <= '0;
                            r_mcand <= {{WIDTH{1'b0}}, w_abs1};
                            r_mplr  <= w_abs2;
                            r_neg   <= s1[WIDTH-1] ^ s2[WIDTH-1];
                        end else begin
                            r_result    <= w_res;
                            r_flags     <= w_fl;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    r_acc   <= w_acc_sum;
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    if (r_count == '0) begin
                        r_state     <= IDLE;
                        r_result    <= w_prod[WIDTH-1:0];
                        r_flags     <= {(w_prod[WIDTH-1:0] == '0), w_prod[WIDTH-1], r_flags[1], w_mul_v};
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Directed and streamed bench for alu_mc with an in-order scoreboard of expected result, flags and latency.
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] s1, s2, imm, ex_in;
    logic         out_valid;
    logic [W-1:0] result;
    logic [3:0]   flags;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           lat;
        int           cyc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mfl;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         n_push = 0;
    int         n_pop = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .s1(s1), .s2(s2), .imm(imm), .ex_in(ex_in),
        .out_valid(out_valid), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model written in plain integer arithmetic.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] a, b, im, ex,
                                  input logic [3:0] fin, output logic [3:0] fout, output logic [W-1:0] r);
        longint ua, ub, sa, sb, t, mx, mn;
        logic z, n, c, v, zn;
        int amt;
        ua = longint'(a); ub = longint'(b);
        sa = longint'($signed(a)); sb = longint'($signed(b));
        mx = 2 ** (W - 1) - 1; mn = -(2 ** (W - 1));
        {z, n, c, v} = fin;
        zn = 1'b1;
        r = '0;
        amt = int'(b) % W;
        case (o)
            4'h1: begin t = ua + ub; r = t[W-1:0]; c = (t >= 2 ** W); t = sa + sb; v = (t > mx) || (t < mn); end
            4'h2: begin t = ua - ub; r = t[W-1:0]; c = (ua < ub); t = sa - sb; v = (t > mx) || (t < mn); end
            4'h3: r = ~(a & b);
            4'h4: begin r = a << 1; c = a[W-1]; end
            4'h5: begin r = a >> 1; c = a[0]; end
            4'h9: begin t = sa * sb; r = t[W-1:0]; v = (t > mx) || (t < mn); end
            4'hA: begin r = a; c = 1'b0; for (int i = 0; i < amt; i++) begin c = r[W-1]; r = r << 1; end end
            4'hB: begin r = a; c = 1'b0; for (int i = 0; i < amt; i++) begin c = r[0]; r = r >> 1; end end
            default: begin
                zn = 1'b0;
                case (o)
                    4'h6, 4'hE: r = a;
                    4'h7: r = ex;
                    4'h8: r = b;
                    4'hF: r = im;
                    default: r = '0;
                endcase
            end
        endcase
        if (zn) begin z = (r == '0); n = r[W-1]; end
        fout = {z, n, c, v};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            chk("unexpected_out_valid", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                n_pop++;
                chk("result", result, e.res);
                chk("flags", flags, e.fl);
                chk("latency", cyc - e.cyc, e.lat);
                if (e.lat != 0) chk("mul_ready_at_done", in_ready, 1);
            end
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] a, b, im, ex);
        exp_t e;
        int n;
        @(negedge clk);
        op = o; s1 = a; s2 = b; imm = im; ex_in = ex; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
            return;
        end
        @(posedge clk); #1;
        model(o, a, b, im, ex, mfl, mfl, e.res);
        e.fl = mfl;
        e.lat = (o == 4'h9) ? W : 0;
        e.cyc = cyc;
        q.push_back(e);
        n_push++;
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
        chk("drain", q.size(), 0);
    endtask

    task automatic expect_state(input string tag, input logic [W-1:0] r, input logic [3:0] f);
        drain();
        chk({tag, "_res"}, result, r);
        chk({tag, "_flags"}, flags, f);
    endtask

    initial begin
        int lows;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; s1 = '0; s2 = '0; imm = '0; ex_in = '0;
        mfl = '0;
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", flags, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_ready", in_ready, 1);

        do_op(4'h1, 8'h7F, 8'h01, 0, 0);  expect_state("add_ovf", 8'h80, 4'b0101);
        do_op(4'h1, 8'hFF, 8'h01, 0, 0);  expect_state("add_carry", 8'h00, 4'b1010);
        do_op(4'h2, 8'h05, 8'h05, 0, 0);  expect_state("sub_zero", 8'h00, 4'b1000);
        do_op(4'h2, 8'h03, 8'h05, 0, 0);  expect_state("sub_borrow", 8'hFE, 4'b0110);

        do_op(4'h9, 8'hFD, 8'h07, 0, 0);
        in_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 50 && !in_ready; i++) begin @(negedge clk); #1; if (!in_ready) lows++; end
        chk("mul_ready_low", (lows >= W - 1), 1);
        expect_state("mul_neg", 8'hEB, 4'b0110);
        do_op(4'h9, 8'h10, 8'h10, 0, 0);  expect_state("mul_ovf", 8'h00, 4'b1011);

        do_op(4'hA, 8'h81, 8'h01, 0, 0);  expect_state("shln1", 8'h02, 4'b0011);
        do_op(4'hB, 8'h81, 8'h00, 0, 0);  expect_state("shrn0", 8'h81, 4'b0101);
        do_op(4'hB, 8'h80, 8'h07, 0, 0);  expect_state("shrn7", 8'h01, 4'b0001);
        do_op(4'hF, 0, 0, 8'h55, 0);      expect_state("ldimm", 8'h55, 4'b0001);
        do_op(4'hC, 8'h12, 8'h34, 0, 0);  expect_state("undef", 8'h00, 4'b0001);

        do_op(4'h9, 8'h05, 8'h06, 0, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_ready", in_ready, 1);
        q.delete();
        n_push = n_pop;
        mfl = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        do_op(4'h1, 8'h02, 8'h02, 0, 0);  expect_state("add_after_rst", 8'h04, 4'b0000);

        do_op(4'h1, 8'h11, 8'h22, 0, 0);
        do_op(4'h3, 8'hF0, 8'h3C, 0, 0);
        do_op(4'h7, 0, 0, 0, 8'h3C);
        do_op(4'h9, 8'h83, 8'h05, 0, 0);
        do_op(4'h8, 8'h00, 8'hA5, 0, 0);
        expect_state("stream_mov", 8'hA5, mfl);

        for (int k = 0; k < 24; k++) begin
            do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        drain();
        chk("one_output_per_op", n_pop, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
